// File: rtl/rwc_irq_pkg.sv
// Shared constants and address helper for the RW1C interrupt status bank.
// Each register region (status, mask, overflow) is NUM_REG words wide.
package rwc_irq_pkg;

   localparam int STS_OFS = 0;
   localparam int MSK_OFS = 1;
   localparam int OVF_OFS = 2;

   function automatic logic addr_hit(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] idx);
      return addr == (base + idx);
   endfunction

endpackage

// File: rtl/rwc_irq_bank_if.sv
// CPU register bus for the interrupt status bank.
// Strobe semantics: a write or read completes in the single cycle its strobe is high;
// there is no ready/backpressure, and o_rdata is combinational and valid while i_ren is high.
interface rwc_irq_bank_if #(
   parameter int DW = 8,
   parameter int AW = 8
);
   logic          i_wen;
   logic          i_ren;
   logic          i_test_mode_status;
   logic          i_cfg_mode_status;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_wdata;
   logic [DW-1:0] o_rdata;

   modport master (
      output i_wen, i_ren, i_test_mode_status, i_cfg_mode_status, i_addr, i_wdata,
      input  o_rdata
   );

   modport slave (
      input  i_wen, i_ren, i_test_mode_status, i_cfg_mode_status, i_addr, i_wdata,
      output o_rdata
   );
endinterface

// File: rtl/rwc_irq_word.sv
// One status word: edge history, RW1C status, RW mask, RW1C overflow and its pending bit.
// Hardware sets always win over a same-cycle CPU clear so no event is lost.
module rwc_irq_word #(
   parameter int            DW           = 8,
   parameter logic [DW-1:0] DEFAULT_MASK = '1,
   parameter logic          EVT_EDGE     = 1'b1
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic [DW-1:0] i_evt,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_sts_we,
   input  logic          i_msk_we,
   input  logic          i_ovf_we,
   output logic [DW-1:0] o_sts,
   output logic [DW-1:0] o_msk,
   output logic [DW-1:0] o_ovf,
   output logic          o_pend,
   output logic          o_pend_nxt
);

   logic [DW-1:0] evt_d;
   logic [DW-1:0] evt;
   logic [DW-1:0] sts_clr;
   logic [DW-1:0] ovf_clr;
   logic [DW-1:0] sts_nxt;
   logic [DW-1:0] ovf_nxt;
   logic [DW-1:0] msk_nxt;

   assign evt     = EVT_EDGE ? (i_evt & ~evt_d) : i_evt;
   assign sts_clr = i_sts_we ? i_wdata : '0;
   assign ovf_clr = i_ovf_we ? i_wdata : '0;

   // Overflow only counts an event that lands on a bit still pending after this cycle's clear.
   assign sts_nxt = evt | (o_sts & ~sts_clr);
   assign ovf_nxt = (evt & o_sts & ~sts_clr) | (o_ovf & ~ovf_clr);
   assign msk_nxt = i_msk_we ? i_wdata : o_msk;

   assign o_pend_nxt = |(sts_nxt & ~msk_nxt);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         evt_d  <= '0;
         o_sts  <= '0;
         o_msk  <= DEFAULT_MASK;
         o_ovf  <= '0;
         o_pend <= 1'b0;
      end else begin
         evt_d  <= i_evt;
         o_sts  <= sts_nxt;
         o_msk  <= msk_nxt;
         o_ovf  <= ovf_nxt;
         o_pend <= o_pend_nxt;
      end
   end

endmodule

// File: rtl/rwc_irq_bank.sv
// Bank of NUM_REG RW1C status words with masks, overflow capture and one registered interrupt.
// Handles address decode, test/cfg mode gating, the read mux and the interrupt OR.
module rwc_irq_bank
   import rwc_irq_pkg::*;
#(
   parameter int            DW                   = 8,
   parameter int            AW                   = 8,
   parameter int            NUM_REG              = 4,
   parameter logic [AW-1:0] BASE_ADDR            = 8'h40,
   parameter logic [DW-1:0] DEFAULT_MASK         = '1,
   parameter logic          EVT_EDGE             = 1'b1,
   parameter logic          SUPPORT_TEST_MODE_WR = 1'b1,
   parameter logic          SUPPORT_TEST_MODE_RD = 1'b1,
   parameter logic          SUPPORT_CFG_MODE_WR  = 1'b1,
   parameter logic          SUPPORT_CFG_MODE_RD  = 1'b1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   rwc_irq_bank_if.slave         bus,
   input  logic [NUM_REG*DW-1:0] i_lgc_evt,
   output logic [NUM_REG-1:0]    o_irq_vec,
   output logic                  o_irq
);

   logic [31:0]        addr_ext;
   logic               wr_ok;
   logic               rd_ok;
   logic [NUM_REG-1:0] hit_s;
   logic [NUM_REG-1:0] hit_m;
   logic [NUM_REG-1:0] hit_o;
   logic [NUM_REG-1:0] pend_nxt;
   logic               wen;
   logic               ren;
   logic [DW-1:0]      sts [NUM_REG];
   logic [DW-1:0]      msk [NUM_REG];
   logic [DW-1:0]      ovf [NUM_REG];

   assign addr_ext = 32'(bus.i_addr);
   assign wr_ok = (bus.i_test_mode_status & SUPPORT_TEST_MODE_WR) |
                  (bus.i_cfg_mode_status  & SUPPORT_CFG_MODE_WR);
   assign rd_ok = (bus.i_test_mode_status & SUPPORT_TEST_MODE_RD) |
                  (bus.i_cfg_mode_status  & SUPPORT_CFG_MODE_RD);
   assign wen = bus.i_wen & wr_ok & (|{hit_s, hit_m, hit_o});
   assign ren = bus.i_ren & rd_ok & (|{hit_s, hit_m, hit_o});

   for (genvar k = 0; k < NUM_REG; k++) begin : g_word
      assign hit_s[k] = addr_hit(addr_ext, 32'(BASE_ADDR), 32'(STS_OFS * NUM_REG + k));
      assign hit_m[k] = addr_hit(addr_ext, 32'(BASE_ADDR), 32'(MSK_OFS * NUM_REG + k));
      assign hit_o[k] = addr_hit(addr_ext, 32'(BASE_ADDR), 32'(OVF_OFS * NUM_REG + k));

      rwc_irq_word #(
         .DW           (DW),
         .DEFAULT_MASK (DEFAULT_MASK),
         .EVT_EDGE     (EVT_EDGE)
      ) u_word (
         .i_clk      (i_clk),
         .i_rst_n    (i_rst_n),
         .i_evt      (i_lgc_evt[k*DW +: DW]),
         .i_wdata    (bus.i_wdata),
         .i_sts_we   (wen & hit_s[k]),
         .i_msk_we   (wen & hit_m[k]),
         .i_ovf_we   (wen & hit_o[k]),
         .o_sts      (sts[k]),
         .o_msk      (msk[k]),
         .o_ovf      (ovf[k]),
         .o_pend     (o_irq_vec[k]),
         .o_pend_nxt (pend_nxt[k])
      );
   end

   always_comb begin
      bus.o_rdata = '0;
      if (ren) begin
         for (int k = 0; k < NUM_REG; k++) begin
            if (hit_s[k]) bus.o_rdata = sts[k];
            if (hit_m[k]) bus.o_rdata = msk[k];
            if (hit_o[k]) bus.o_rdata = ovf[k];
         end
      end
   end

   // Built from next-state pending so o_irq lines up with o_irq_vec on the same edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) o_irq <= 1'b0;
      else          o_irq <= |pend_nxt;
   end

endmodule

// File: tb/tb_rwc_irq_bank.sv
// Scoreboard bench for rwc_irq_bank: an edge-mode and a level-mode instance share one bus,
// checked against an address-map level model of the register bank.
module tb_rwc_irq_bank;

   localparam int         DW   = 8;
   localparam int         AW   = 8;
   localparam int         NR   = 4;
   localparam logic [7:0] BASE = 8'h40;
   localparam int         EW   = NR * DW;

   logic          i_clk   = 1'b0;
   logic          i_rst_n = 1'b0;
   logic [EW-1:0] lgc_evt;
   logic [NR-1:0] vec_e, vec_l;
   logic          irq_e, irq_l;
   logic          mon_on = 1'b0;
   int            checks = 0;
   int            errors = 0;

   logic [DW-1:0] m_sts [2][NR];
   logic [DW-1:0] m_msk [2][NR];
   logic [DW-1:0] m_ovf [2][NR];
   logic [EW-1:0] m_prev;

   logic [2*DW-1:0]   exp_rd_q  [$];
   logic [2*NR+1:0]   exp_irq_q [$];

   always #5 i_clk = ~i_clk;

   rwc_irq_bank_if #(.DW(DW), .AW(AW)) bif_e ();
   rwc_irq_bank_if #(.DW(DW), .AW(AW)) bif_l ();

   rwc_irq_bank #(
      .DW(DW), .AW(AW), .NUM_REG(NR), .BASE_ADDR(BASE), .DEFAULT_MASK('1),
      .EVT_EDGE(1'b1), .SUPPORT_TEST_MODE_WR(1'b1), .SUPPORT_TEST_MODE_RD(1'b1),
      .SUPPORT_CFG_MODE_WR(1'b0), .SUPPORT_CFG_MODE_RD(1'b1)
   ) dut_e (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bif_e.slave),
      .i_lgc_evt(lgc_evt), .o_irq_vec(vec_e), .o_irq(irq_e)
   );

   rwc_irq_bank #(
      .DW(DW), .AW(AW), .NUM_REG(NR), .BASE_ADDR(BASE), .DEFAULT_MASK('1),
      .EVT_EDGE(1'b0), .SUPPORT_TEST_MODE_WR(1'b1), .SUPPORT_TEST_MODE_RD(1'b1),
      .SUPPORT_CFG_MODE_WR(1'b0), .SUPPORT_CFG_MODE_RD(1'b1)
   ) dut_l (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bif_l.slave),
      .i_lgc_evt(lgc_evt), .o_irq_vec(vec_l), .o_irq(irq_l)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++)
         for (int k = 0; k < NR; k++) begin
            m_sts[i][k] = '0;
            m_msk[i][k] = '1;
            m_ovf[i][k] = '0;
         end
      m_prev = '0;
   endtask

   // Region = offset / NR, word = offset % NR; anything past three regions is unmapped.
   function automatic logic [DW-1:0] model_read(input int inst, input logic [AW-1:0] addr);
      int off;
      off = int'(addr) - int'(BASE);
      if (off < 0 || off >= 3 * NR) return '0;
      case (off / NR)
         0:       return m_sts[inst][off % NR];
         1:       return m_msk[inst][off % NR];
         default: return m_ovf[inst][off % NR];
      endcase
   endfunction

   task automatic cyc(input logic wen, input logic ren, input logic test, input logic cfg,
                      input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input logic [EW-1:0] evt);
      int            off;
      logic          wr_ok, rd_ok;
      logic [DW-1:0] rd [2];
      logic [DW-1:0] ev, cs, co, old;
      logic [NR-1:0] vec [2];
      @(negedge i_clk);
      bif_e.i_wen = wen;  bif_e.i_ren = ren;  bif_e.i_test_mode_status = test;
      bif_e.i_cfg_mode_status = cfg;  bif_e.i_addr = addr;  bif_e.i_wdata = wdata;
      bif_l.i_wen = wen;  bif_l.i_ren = ren;  bif_l.i_test_mode_status = test;
      bif_l.i_cfg_mode_status = cfg;  bif_l.i_addr = addr;  bif_l.i_wdata = wdata;
      lgc_evt = evt;
      mon_on  = 1'b1;
      wr_ok = wen & test;
      rd_ok = test | cfg;
      off   = int'(addr) - int'(BASE);
      for (int i = 0; i < 2; i++) rd[i] = rd_ok ? model_read(i, addr) : '0;
      if (ren) exp_rd_q.push_back({rd[1], rd[0]});
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < NR; k++) begin
            ev  = (i == 0) ? (evt[k*DW +: DW] & ~m_prev[k*DW +: DW]) : evt[k*DW +: DW];
            cs  = (wr_ok && off == k)        ? wdata : '0;
            co  = (wr_ok && off == 2*NR + k) ? wdata : '0;
            old = m_sts[i][k];
            m_sts[i][k] = ev | (old & ~cs);
            m_ovf[i][k] = (ev & old & ~cs) | (m_ovf[i][k] & ~co);
            if (wr_ok && off == NR + k) m_msk[i][k] = wdata;
            vec[i][k] = |(m_sts[i][k] & ~m_msk[i][k]);
         end
      end
      m_prev = evt;
      exp_irq_q.push_back({|vec[1], vec[1], |vec[0], vec[0]});
   endtask

   task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] d, input logic [EW-1:0] evt);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, addr, d, evt);
   endtask

   task automatic rd(input logic [AW-1:0] addr, input logic [EW-1:0] evt);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, addr, '0, evt);
   endtask

   // Reset dropped mid-cycle with the event input left as it is.
   task automatic async_reset();
      @(negedge i_clk);
      mon_on = 1'b0;
      #2 i_rst_n = 1'b0;
      #1;
      chk("rst_irq_e", 32'(irq_e), 0);
      chk("rst_vec_e", 32'(vec_e), 0);
      chk("rst_irq_l", 32'(irq_l), 0);
      chk("rst_vec_l", 32'(vec_l), 0);
      model_reset();
      @(posedge i_clk);
      #1 i_rst_n = 1'b1;
   endtask

   // Monitor: read data just before the edge when a read is presented, interrupts just after.
   initial begin
      logic [2*DW-1:0] er;
      logic [2*NR+1:0] ei;
      forever begin
         @(negedge i_clk);
         #4;
         if (mon_on) begin
            if (bif_e.i_ren) begin
               if (exp_rd_q.size() == 0) chk("rd_q_underflow", 1, 0);
               else begin
                  er = exp_rd_q.pop_front();
                  chk("rdata_edge", 32'(bif_e.o_rdata), 32'(er[DW-1:0]));
                  chk("rdata_level", 32'(bif_l.o_rdata), 32'(er[2*DW-1:DW]));
               end
            end
            @(posedge i_clk);
            #1;
            if (exp_irq_q.size() == 0) chk("irq_q_underflow", 1, 0);
            else begin
               ei = exp_irq_q.pop_front();
               chk("irq_edge", 32'({irq_e, vec_e}), 32'(ei[NR:0]));
               chk("irq_level", 32'({irq_l, vec_l}), 32'(ei[2*NR+1:NR+1]));
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bif_e.i_wen = 0; bif_e.i_ren = 0; bif_e.i_test_mode_status = 0;
      bif_e.i_cfg_mode_status = 0; bif_e.i_addr = '0; bif_e.i_wdata = '0;
      bif_l.i_wen = 0; bif_l.i_ren = 0; bif_l.i_test_mode_status = 0;
      bif_l.i_cfg_mode_status = 0; bif_l.i_addr = '0; bif_l.i_wdata = '0;
      lgc_evt = '0;
      model_reset();
      repeat (2) @(negedge i_clk);
      chk("reset_irq", 32'({irq_l, irq_e}), 0);
      chk("reset_vec", 32'({vec_l, vec_e}), 0);
      i_rst_n = 1'b1;

      // Reset values of every mapped word, then a read with both modes low.
      for (int a = 0; a < 3 * NR; a++) rd(BASE + 8'(a), '0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, BASE + 8'(NR), '0, '0);

      // Unmask word 0, one-cycle event on bit 3, then clear it.
      wr(BASE + 8'(NR), 8'h00, '0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 32'h08);
      rd(BASE, '0);
      wr(BASE, 8'h08, '0);
      rd(BASE, '0);

      // Set and W1C on the same bit in one cycle.
      wr(BASE, 8'h04, 32'h04);
      rd(BASE, '0);
      rd(BASE + 8'(2*NR), '0);
      wr(BASE + 8'(2*NR), 8'h04, '0);
      wr(BASE, 8'h04, '0);

      // Bit 0 held high: one set in edge mode, re-set every cycle in level mode.
      repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 32'h01);
      wr(BASE, 8'h01, 32'h01);
      rd(BASE, 32'h01);
      rd(BASE + 8'(2*NR), 32'h01);
      wr(BASE + 8'(2*NR), 8'hFF, '0);
      wr(BASE, 8'hFF, '0);

      // Masked pending bit on word 1, then unmask, then async reset with the input held.
      wr(BASE + 8'(NR + 1), 8'h01, '0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 32'h100);
      rd(BASE + 8'd1, '0);
      wr(BASE + 8'(NR + 1), 8'h00, '0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 32'h100);
      async_reset();
      cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 32'h100);
      rd(BASE + 8'd1, 32'h100);
      rd(BASE + 8'd1, '0);

      // cfg-only write ignored, test-mode write lands, unmapped address inert.
      cyc(1'b1, 1'b0, 1'b0, 1'b1, BASE + 8'(NR + 2), 8'h00, '0);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, BASE + 8'(NR + 2), '0, '0);
      wr(BASE + 8'(NR + 2), 8'h5A, '0);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, BASE + 8'(NR + 2), '0, '0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, BASE + 8'(3*NR), 8'hFF, '0);
      rd(BASE + 8'(3*NR), '0);
      rd(BASE - 8'd1, '0);

      // Random traffic around the mapped window.
      for (int n = 0; n < 600; n++) begin
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             BASE - 8'd2 + 8'($urandom_range(0, 3*NR + 3)),
             8'($urandom), $urandom & $urandom & $urandom);
      end

      @(negedge i_clk);
      mon_on = 1'b0;
      repeat (3) @(posedge i_clk);
      chk("rd_q_leftover", 32'(exp_rd_q.size()), 0);
      chk("irq_q_leftover", 32'(exp_irq_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
